// File: rtl/mem_stage_if.sv
// Shared widths and the access-size type, plus the bundled port view of the memory stage.
// Latency: none, wiring only.
// Backpressure: carried by mem_stall_o (upstream hold) and dmem_ack_i (memory completion).
package params_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int REGISTER_WIDTH = 5;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } access_size_t;
endpackage

interface mem_stage_if #(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
);
  // execute-stage request
  logic                       mem_valid_i;
  logic                       mem_is_load_i;
  logic                       mem_is_store_i;
  logic                       mem_reg_wr_en_i;
  logic [REGISTER_WIDTH-1:0]  mem_wr_reg_i;
  logic [DATA_WIDTH-1:0]      mem_alu_result_i;
  logic [DATA_WIDTH-1:0]      mem_rs2_data_i;
  params_pkg::access_size_t   mem_access_size_i;
  logic                       mem_stall_o;

  // data memory request/acknowledge
  logic                       dmem_req_o;
  logic                       dmem_we_o;
  logic [ADDR_WIDTH-1:0]      dmem_addr_o;
  logic [DATA_WIDTH-1:0]      dmem_wdata_o;
  logic [DATA_WIDTH/8-1:0]    dmem_be_o;
  logic                       dmem_ack_i;
  logic [DATA_WIDTH-1:0]      dmem_rdata_i;

  // writeback result
  logic                       wb_valid_o;
  logic                       wb_reg_wr_en_o;
  logic [REGISTER_WIDTH-1:0]  wb_wr_reg_o;
  logic [DATA_WIDTH-1:0]      wb_data_o;

  // environment side: execute stage, data memory and register file
  modport master (
    output mem_valid_i, mem_is_load_i, mem_is_store_i, mem_reg_wr_en_i,
    output mem_wr_reg_i, mem_alu_result_i, mem_rs2_data_i, mem_access_size_i,
    input  mem_stall_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_ack_i, dmem_rdata_i,
    input  wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o
  );

  // memory stage side
  modport slave (
    input  mem_valid_i, mem_is_load_i, mem_is_store_i, mem_reg_wr_en_i,
    input  mem_wr_reg_i, mem_alu_result_i, mem_rs2_data_i, mem_access_size_i,
    output mem_stall_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_ack_i, dmem_rdata_i,
    output wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one load/store per request/acknowledge transaction, then a writeback pulse.
// Latency: k+1 cycles from accept to wb_valid_o when memory acks in the k-th request cycle.
// Backpressure: mem_stall_o holds the execute stage until the ack cycle; dmem_req_o held until ack.
module mem_stage #(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
  input logic        clk_i,
  input logic        rst_i,
  mem_stage_if.slave bus
);
  import params_pkg::*;

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic accept;
  logic ack_seen;
  logic stall;

  // captured request; the memory-facing copies are built at capture time so the
  // dmem_* outputs come straight from flops
  logic                      req_q;
  logic                      we_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [BE_WIDTH-1:0]       be_q;
  logic [1:0]                lane_q;
  logic                      is_word_q;
  logic                      reg_wr_en_q;
  logic [REGISTER_WIDTH-1:0] wr_reg_q;

  logic                      wb_valid_q;
  logic                      wb_reg_wr_en_q;
  logic [REGISTER_WIDTH-1:0] wb_wr_reg_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;

  logic [7:0]                load_byte;
  logic [DATA_WIDTH-1:0]     load_data;

  // a valid instruction with neither flag set is not a memory op and is ignored
  assign accept   = bus.mem_valid_i & (bus.mem_is_load_i | bus.mem_is_store_i);
  // ack outside ACCESS carries no meaning
  assign ack_seen = (state_q == ACCESS) & bus.dmem_ack_i;

  // LB picks the addressed lane and sign-extends; misaligned word loads ignore addr[1:0]
  assign load_byte = bus.dmem_rdata_i[{lane_q, 3'b000} +: 8];
  assign load_data = is_word_q ? bus.dmem_rdata_i
                               : {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and stall; stall drops in the ack cycle so upstream advances on the same edge we return to IDLE
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          stall   = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.dmem_ack_i) state_d = IDLE;
        else                stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the instruction on accept and hold the memory request until it is acknowledged
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      lane_q      <= 2'b00;
      is_word_q   <= 1'b0;
      reg_wr_en_q <= 1'b0;
      wr_reg_q    <= '0;
    end else if ((state_q == IDLE) && accept) begin
      req_q       <= 1'b1;
      // both flags set resolves to a load
      we_q        <= ~bus.mem_is_load_i;
      addr_q      <= {bus.mem_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
      lane_q      <= bus.mem_alu_result_i[1:0];
      is_word_q   <= (bus.mem_access_size_i == WORD);
      reg_wr_en_q <= bus.mem_reg_wr_en_i;
      wr_reg_q    <= bus.mem_wr_reg_i;
      if (bus.mem_access_size_i == WORD) begin
        be_q    <= '1;
        wdata_q <= bus.mem_rs2_data_i;
      end else begin
        be_q    <= BE_WIDTH'(1'b1) << bus.mem_alu_result_i[1:0];
        wdata_q <= {BE_WIDTH{bus.mem_rs2_data_i[7:0]}};
      end
    end else if (ack_seen) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
    end
  end

  // one-cycle writeback pulse loaded at the edge that ends the ack cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_q     <= 1'b0;
      wb_reg_wr_en_q <= 1'b0;
      wb_wr_reg_q    <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= ack_seen;
      wb_reg_wr_en_q <= ack_seen & ~we_q & reg_wr_en_q;
      if (ack_seen) begin
        wb_wr_reg_q <= wr_reg_q;
        wb_data_q   <= we_q ? '0 : load_data;
      end
    end
  end

  assign bus.mem_stall_o    = stall;
  assign bus.dmem_req_o     = req_q;
  assign bus.dmem_we_o      = we_q;
  assign bus.dmem_addr_o    = addr_q;
  assign bus.dmem_wdata_o   = wdata_q;
  assign bus.dmem_be_o      = be_q;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_reg_wr_en_o = wb_reg_wr_en_q;
  assign bus.wb_wr_reg_o    = wb_wr_reg_q;
  assign bus.wb_data_o      = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: execute-stage driver, data-memory responder and writeback scoreboard.
// Latency: expected stall length and writeback contents come from a behavioural model.
// Backpressure: the driver holds each instruction while mem_stall_o is high.
module tb_mem_stage;
  import params_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          k;
  } mreq_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int idle_ack_req = 0;

  mreq_t mq[$];
  wb_t   wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one instruction (called just after a rising edge), push the expected memory
  // transaction and writeback, then hold it until the stage stops stalling.
  task automatic issue(input logic ld, input logic st, input logic wren, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic word,
                       input logic [31:0] rdata, input int k);
    mreq_t       m;
    wb_t         w;
    logic [1:0]  lane;
    logic [31:0] b;
    int          n;
    bit          done;
    lane = addr[1:0];
    bus.mem_valid_i       = 1'b1;
    bus.mem_is_load_i     = ld;
    bus.mem_is_store_i    = st;
    bus.mem_reg_wr_en_i   = wren;
    bus.mem_wr_reg_i      = rd;
    bus.mem_alu_result_i  = addr;
    bus.mem_rs2_data_i    = rs2;
    bus.mem_access_size_i = word ? WORD : BYTE;
    if (ld || st) begin
      m.addr  = addr & 32'hFFFF_FFFC;
      m.we    = !ld;
      m.be    = word ? 4'hF : (4'h1 << lane);
      m.wdata = word ? rs2 : (rs2 & 32'hFF) * 32'h0101_0101;
      m.rdata = rdata;
      m.k     = k;
      mq.push_back(m);
      w.en = ld & wren;
      w.rd = rd;
      if (!ld)       w.data = 32'h0;
      else if (word) w.data = rdata;
      else begin
        b      = (rdata >> (8 * lane)) & 32'hFF;
        w.data = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      end
      wq.push_back(w);
    end
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk); #1;
      if (bus.mem_stall_o) n++;
      else                 done = 1'b1;
    end
    chk("stall_released", 32'(done), 32'd1);
    chk("stall_cycles", n, (ld || st) ? k : 0);
    @(posedge clk); #1;
    bus.mem_valid_i    = 1'b0;
    bus.mem_is_load_i  = 1'b0;
    bus.mem_is_store_i = 1'b0;
  endtask

  // data memory: checks each request cycle against the model and acks in the k-th cycle
  initial begin
    mreq_t cur;
    int    cnt;
    bit    busy;
    int    idle_ack_done;
    busy             = 1'b0;
    cnt              = 0;
    idle_ack_done    = 0;
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.dmem_ack_i = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (bus.dmem_req_o) begin
        if (!busy) begin
          chk("req_expected", 32'(mq.size() != 0), 32'd1);
          if (mq.size() != 0) begin
            cur  = mq.pop_front();
            busy = 1'b1;
            cnt  = 0;
          end
        end
        if (busy) begin
          cnt++;
          chk("dmem_addr", bus.dmem_addr_o, cur.addr);
          chk("dmem_we", 32'(bus.dmem_we_o), 32'(cur.we));
          if (cur.we) begin
            chk("dmem_be", 32'(bus.dmem_be_o), 32'(cur.be));
            chk("dmem_wdata", bus.dmem_wdata_o, cur.wdata);
          end
          if (cnt == cur.k) begin
            bus.dmem_ack_i   = 1'b1;
            bus.dmem_rdata_i = cur.rdata;
            busy             = 1'b0;
          end
        end
      end else begin
        if (busy) begin
          chk("req_held", 32'(bus.dmem_req_o), 32'd1);
          busy = 1'b0;
        end
        if (idle_ack_done < idle_ack_req) begin
          bus.dmem_ack_i   = 1'b1;
          bus.dmem_rdata_i = $urandom;
          idle_ack_done++;
        end
      end
    end
  end

  // writeback monitor: every pulse must match the oldest expected result and last one cycle
  initial begin
    wb_t  w;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (bus.wb_valid_o) begin
          chk("wb_single_cycle", 32'(prev), 32'd0);
          chk("wb_expected", 32'(wq.size() != 0), 32'd1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wb_reg_wr_en", 32'(bus.wb_reg_wr_en_o), 32'(w.en));
            chk("wb_wr_reg", 32'(bus.wb_wr_reg_o), 32'(w.rd));
            chk("wb_data", bus.wb_data_o, w.data);
          end
        end else begin
          chk("wb_wren_idle", 32'(bus.wb_reg_wr_en_o), 32'd0);
        end
        prev = bus.wb_valid_o;
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    mreq_t m;
    int    r;
    bus.mem_valid_i       = 1'b0;
    bus.mem_is_load_i     = 1'b0;
    bus.mem_is_store_i    = 1'b0;
    bus.mem_reg_wr_en_i   = 1'b0;
    bus.mem_wr_reg_i      = 5'd0;
    bus.mem_alu_result_i  = 32'h0;
    bus.mem_rs2_data_i    = 32'h0;
    bus.mem_access_size_i = BYTE;

    // reset state
    #3;
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_we", 32'(bus.dmem_we_o), 32'd0);
    chk("rst_stall", 32'(bus.mem_stall_o), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_wb_wren", 32'(bus.wb_reg_wr_en_o), 32'd0);
    chk("rst_addr", bus.dmem_addr_o, 32'h0);
    chk("rst_wdata", bus.dmem_wdata_o, 32'h0);
    chk("rst_be", 32'(bus.dmem_be_o), 32'h0);
    chk("rst_wb_reg", 32'(bus.wb_wr_reg_o), 32'h0);
    chk("rst_wb_data", bus.wb_data_o, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word store, immediate ack
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h104, 32'hDEADBEEF, 1'b1, 32'h0, 1);
    // byte store to the top lane
    issue(1'b0, 1'b1, 1'b1, 5'd4, 32'h203, 32'h0000_00A5, 1'b0, 32'h0, 1);
    // LB with sign extension, ack after 3 request cycles
    issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h301, 32'h0, 1'b0, 32'h0000_8000, 3);
    // word load immediately followed by a store
    issue(1'b1, 1'b0, 1'b1, 5'd9, 32'h400, 32'h0, 1'b1, 32'h1234_5678, 2);
    issue(1'b0, 1'b1, 1'b0, 5'd2, 32'h408, 32'hCAFE_F00D, 1'b1, 32'h0, 1);
    // neither flag set: no request, no stall
    issue(1'b0, 1'b0, 1'b1, 5'd5, 32'h500, 32'h0, 1'b1, 32'h0, 1);
    // both flags set behaves as a load
    issue(1'b1, 1'b1, 1'b1, 5'd3, 32'h502, 32'h0, 1'b0, 32'h0042_0000, 2);
    // misaligned word load ignores addr[1:0]
    issue(1'b1, 1'b0, 1'b1, 5'd11, 32'h603, 32'h0, 1'b1, 32'h8765_4321, 1);

    // ack while idle must do nothing
    idle_ack_req++;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("idle_ack_no_req", 32'(bus.dmem_req_o), 32'd0);
    chk("idle_ack_no_stall", 32'(bus.mem_stall_o), 32'd0);
    @(posedge clk); #1;

    // reset while the request is outstanding: nothing is written back
    m.addr = 32'h700; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0; m.rdata = 32'h0; m.k = 1000;
    mq.push_back(m);
    bus.mem_valid_i       = 1'b1;
    bus.mem_is_load_i     = 1'b1;
    bus.mem_is_store_i    = 1'b0;
    bus.mem_reg_wr_en_i   = 1'b1;
    bus.mem_wr_reg_i      = 5'd12;
    bus.mem_alu_result_i  = 32'h700;
    bus.mem_access_size_i = WORD;
    @(negedge clk); #1;
    chk("abort_stall_idle", 32'(bus.mem_stall_o), 32'd1);
    @(posedge clk); #1;
    bus.mem_valid_i   = 1'b0;
    bus.mem_is_load_i = 1'b0;
    @(negedge clk); #1;
    chk("abort_req_before", 32'(bus.dmem_req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_cleared", 32'(bus.dmem_req_o), 32'd0);
    chk("abort_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("abort_stall", 32'(bus.mem_stall_o), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b1, 5'd13, 32'h710, 32'h0, 1'b1, 32'h0BAD_F00D, 2);

    // randomized mix, including no-op and both-flag instructions and idle gaps
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      issue((r == 1) || (r >= 2 && r <= 5), (r == 1) || (r >= 6),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
            1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("mem_queue_drained", mq.size(), 0);
    chk("wb_queue_drained", wq.size(), 0);
    chk("end_req_idle", 32'(bus.dmem_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multi-cycle pipeline. It consumes the load/store request registered by the execute stage and runs a request/acknowledge transaction against the data memory. It stalls the upstream stage until the memory acknowledges, then presents a one-cycle writeback result for the register file.

## Interface
Parameters:
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): data path width.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH (32): byte address width.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5): register index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  execute stage holds a valid memory instruction.
- mem_is_load_i  in  1  the instruction is a load.
- mem_is_store_i  in  1  the instruction is a store.
- mem_reg_wr_en_i  in  1  the instruction writes rd.
- mem_wr_reg_i  in  REGISTER_WIDTH  destination register.
- mem_alu_result_i  in  DATA_WIDTH  effective byte address; only the low ADDR_WIDTH bits are used.
- mem_rs2_data_i  in  DATA_WIDTH  store data.
- mem_access_size_i  in  access_size_t  BYTE or WORD.
- mem_stall_o  out  1  holds the execute-stage output registers.
- dmem_req_o  out  1  memory request, held until acknowledged.
- dmem_we_o  out  1  1 for a store, 0 for a load.
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address, with bits [1:0] forced to 0.
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- dmem_be_o  out  DATA_WIDTH/8  byte enables.
- dmem_ack_i  in  1  one-cycle acknowledge; dmem_rdata_i is valid in the same cycle.
- dmem_rdata_i  in  DATA_WIDTH  read data (full word).
- wb_valid_o  out  1  one-cycle pulse: the memory instruction has completed.
- wb_reg_wr_en_o  out  1  write rd in this cycle.
- wb_wr_reg_o  out  REGISTER_WIDTH  destination register.
- wb_data_o  out  DATA_WIDTH  load result.

## Operation
- State machine with two states: IDLE and ACCESS.
- IDLE:
  - Accept condition: mem_valid_i & (mem_is_load_i | mem_is_store_i).
  - On accept: capture the address, store data, size, load flag, reg_wr_en and rd into internal registers, then go to ACCESS.
  - A mem_valid_i with neither flag set is ignored.
  - If both flags are set, the instruction is treated as a load.
- ACCESS:
  - dmem_req_o = 1; all dmem_* outputs are driven from the captured registers and stay stable until the acknowledge.
  - On dmem_ack_i, go to IDLE and load the wb_* registers.
- Stall: mem_stall_o = (IDLE & accept condition) | (ACCESS & ~dmem_ack_i). This is combinational.
- Stall drops in the ack cycle, so the execute stage presents the next instruction at the same edge at which this block returns to IDLE. This prevents a double issue.
- Byte enables and store data:
  - WORD: dmem_be_o = 4'b1111; dmem_wdata_o = rs2.
  - BYTE: dmem_be_o = 4'b0001 << addr[1:0]; dmem_wdata_o = {4{rs2[7:0]}}.
- Load data:
  - WORD: wb_data_o = dmem_rdata_i.
  - BYTE: the lane selected by addr[1:0] is sign-extended to 32 bits (LB).
- Misaligned WORD access: addr[1:0] is ignored; no exception is raised.
- Writeback:
  - wb_valid_o = 1 for one cycle after every completed load or store.
  - wb_reg_wr_en_o = load & captured reg_wr_en.
  - wb_data_o = 0 for stores.
- dmem_ack_i in IDLE is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - dmem_req_o, dmem_we_o, mem_stall_o (with no valid input), wb_valid_o and wb_reg_wr_en_o are 0.
  - dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_wr_reg_o and wb_data_o are 0.
- Reset mid-transaction: dmem_req_o and wb_valid_o clear immediately (asynchronously). The captured request is discarded.
- Latency: if the memory acknowledges in the k-th cycle of dmem_req_o (k ≥ 1):
  - mem_stall_o is high for k cycles: the IDLE cycle plus k−1 ACCESS cycles. It is low in the ack cycle.
  - wb_valid_o rises at the edge that ends the ack cycle and is high for exactly one cycle.
- Minimum occupancy: 2 cycles per memory instruction (IDLE + ACCESS with an immediate ack).
- Back-to-back instructions: the next instruction is accepted in the IDLE cycle that directly follows the ack. There are no bubble cycles beyond that IDLE cycle.
- dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o and dmem_be_o are registered outputs with no combinational path from mem_* inputs.

## Test plan
- Word store, immediate ack: addr 0x104, rs2 0xDEADBEEF, WORD.
  - Expect dmem_addr_o = 0x104, be = 1111, wdata = 0xDEADBEEF, we = 1, stall high for 1 cycle.
  - Expect one wb_valid_o pulse with wb_reg_wr_en_o = 0.
- Byte store: addr 0x203, rs2 0x000000A5, BYTE.
  - Expect dmem_addr_o = 0x200, be = 1000, wdata = 0xA5A5A5A5.
- LB sign extension: addr 0x301, BYTE, rdata 0x00008000, rd = 7, ack after 3 request cycles.
  - Expect mem_stall_o high for 3 cycles and wb_data_o = 0xFFFFFF80.
  - Expect wb_wr_reg_o = 7 with wb_reg_wr_en_o = 1 for one cycle.
- Word load: rdata 0x12345678.
  - Expect wb_data_o = 0x12345678, then immediately accept a following store.
  - Expect no duplicate request and exactly two wb_valid_o pulses.
- Reset mid-ACCESS: assert rst_i low while dmem_req_o = 1.
  - Expect dmem_req_o = 0 before the next clock edge and no wb_valid_o.
  - Expect the FSM to return to IDLE and a new request after reset to complete normally.
- Invalid inputs:
  - mem_valid_i = 1 with neither flag set: expect no request and mem_stall_o = 0.
  - dmem_ack_i pulsed in IDLE: expect no effect.
